// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one operand bit per clock.
// Uses a start/busy/done handshake; the result stays registered until the next conversion completes.
module binary_to_bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  // Decimal digits needed to print the largest WIDTH-bit value.
  function automatic int unsigned min_digits(input int unsigned w);
    longint unsigned v;
    int unsigned     d;
    v = (64'd1 << w) - 64'd1;
    d = 0;
    do begin
      d++;
      v = v / 64'd10;
    end while (v != 64'd0);
    return d;
  endfunction

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("binary_to_bcd_seq: WIDTH must be 2..32");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("binary_to_bcd_seq: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e                state_q;
  logic [WIDTH-1:0]      sh_q;
  logic [4*DIGITS-1:0]   acc_q;
  logic [CntW-1:0]       cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic [4*DIGITS-1:0]   bcd_q;

  logic [4*DIGITS-1:0]   acc_adj;
  logic [4*DIGITS-1:0]   acc_d;
  logic [WIDTH-1:0]      sh_d;

  // Add-3 on every digit >= 5, then shift {acc, sh} left by one.
  always_comb begin
    acc_adj = acc_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
    acc_d = {acc_adj[4*DIGITS-2:0], sh_q[WIDTH-1]};
    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start_i) begin
            sh_q    <= bin_i;
            acc_q   <= '0;
            cnt_q   <= CntW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= StConv;
          end
        end
        StConv: begin
          sh_q  <= sh_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bcd_q   <= acc_d;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Bench for binary_to_bcd_seq: default 8-bit instance plus a 12-bit/4-digit instance,
// checked against a division-based decimal model.
module tb_binary_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, start12;
  logic [7:0]  bin8;
  logic [11:0] bin12;
  logic        busy8, done8, busy12, done12;
  logic [11:0] bcd8;
  logic [15:0] bcd12;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  binary_to_bcd_seq u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start8),
    .bin_i   (bin8),
    .busy_o  (busy8),
    .done_o  (done8),
    .bcd_o   (bcd8)
  );

  binary_to_bcd_seq #(.WIDTH(12), .DIGITS(4)) u_dut12 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start12),
    .bin_i   (bin12),
    .busy_o  (busy12),
    .done_o  (done12),
    .bcd_o   (bcd12)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by repeated division, packed 4 bits per digit.
  function automatic logic [63:0] to_bcd(input int unsigned v, input int unsigned digits);
    logic [63:0] r = '0;
    for (int k = 0; k < int'(digits); k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic run8(input logic [7:0] v);
    int busy_cyc = 0;
    int lat      = 0;
    bit got      = 0;
    bit ok       = 1;
    @(negedge clk);
    start8 = 1'b1;
    bin8   = v;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    bin8   = 8'($urandom);
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (busy8) busy_cyc++;
      if (done8) begin
        got = 1;
        lat = i;
      end
    end
    check_eq("done_seen8", 64'(got), 64'd1);
    check_eq("latency8", 64'(lat), 64'd9);
    check_eq("busy_cycles8", 64'(busy_cyc), 64'd8);
    check_eq("bcd8", 64'(bcd8), to_bcd(v, 3));
    for (int k = 0; k < 3; k++) if (bcd8[4*k +: 4] > 4'd9) ok = 0;
    check_eq("digit_range8", 64'(ok), 64'd1);
    @(negedge clk);
    check_eq("done_one_cycle8", 64'(done8), 64'd0);
    check_eq("bcd_hold8", 64'(bcd8), to_bcd(v, 3));
  endtask

  task automatic run12(input logic [11:0] v);
    int busy_cyc = 0;
    int lat      = 0;
    bit got      = 0;
    @(negedge clk);
    start12 = 1'b1;
    bin12   = v;
    @(posedge clk);
    #1;
    start12 = 1'b0;
    bin12   = 12'($urandom);
    for (int i = 1; i <= 30 && !got; i++) begin
      @(negedge clk);
      if (busy12) busy_cyc++;
      if (done12) begin
        got = 1;
        lat = i;
      end
    end
    check_eq("done_seen12", 64'(got), 64'd1);
    check_eq("latency12", 64'(lat), 64'd13);
    check_eq("busy_cycles12", 64'(busy_cyc), 64'd12);
    check_eq("bcd12", 64'(bcd12), to_bcd(v, 4));
    @(negedge clk);
    check_eq("done_one_cycle12", 64'(done12), 64'd0);
  endtask

  initial begin
    int first_i;
    int second_i;
    int ndone;
    rst_n   = 1'b0;
    start8  = 1'b0;
    start12 = 1'b0;
    bin8    = '0;
    bin12   = '0;
    #12;
    check_eq("rst_busy", 64'(busy8), 64'd0);
    check_eq("rst_done", 64'(done8), 64'd0);
    check_eq("rst_bcd", 64'(bcd8), 64'd0);
    check_eq("rst_bcd12", 64'(bcd12), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run8(8'd0);
    run8(8'd255);
    run8(8'd19);
    run8(8'd100);

    // Full operand sweep, visited in a shuffled order.
    begin
      int order[256];
      for (int i = 0; i < 256; i++) order[i] = i;
      for (int i = 255; i > 0; i--) begin
        int j;
        int t;
        j = int'($urandom_range(i, 0));
        t = order[i];
        order[i] = order[j];
        order[j] = t;
      end
      for (int i = 0; i < 256; i++) run8(8'(order[i]));
    end

    // start held high; bin changes mid-conversion.
    @(negedge clk);
    start8 = 1'b1;
    bin8   = 8'd37;
    @(posedge clk);
    #1;
    bin8     = 8'd200;
    first_i  = 0;
    second_i = 0;
    for (int i = 1; i <= 40 && second_i == 0; i++) begin
      @(negedge clk);
      if (done8) begin
        if (first_i == 0) begin
          first_i = i;
          check_eq("held_first_bcd", 64'(bcd8), 64'h037);
        end else begin
          second_i = i;
          check_eq("held_second_bcd", 64'(bcd8), 64'h200);
          start8 = 1'b0;
        end
      end
    end
    start8 = 1'b0;
    check_eq("held_first_lat", 64'(first_i), 64'd9);
    check_eq("held_second_lat", 64'(second_i), 64'd19);
    repeat (2) @(negedge clk);

    // Extra start pulses during busy must not create extra conversions.
    start8 = 1'b1;
    bin8   = 8'd58;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    ndone  = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      start8 = (i == 3 || i == 5 || i == 9) && busy8;
      if (done8) ndone++;
    end
    start8 = 1'b0;
    check_eq("busy_start_ignored", 64'(ndone), 64'd1);
    check_eq("busy_start_bcd", 64'(bcd8), 64'h058);

    // Asynchronous reset in the middle of converting 99.
    @(negedge clk);
    start8 = 1'b1;
    bin8   = 8'd99;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre_rst_busy", 64'(busy8), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_busy", 64'(busy8), 64'd0);
    check_eq("async_done", 64'(done8), 64'd0);
    check_eq("async_bcd", 64'(bcd8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    check_eq("no_done_after_abort", 64'(ndone), 64'd0);
    run8(8'd99);

    run12(12'd4095);
    run12(12'd0);
    for (int i = 0; i < 8; i++) run12(12'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_seq.md
Name: binary_to_bcd_seq

Overview:
- Iterative binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- It is the reverse path of the team's combinational BCD-to-binary decoder. It turns unsigned binary counts and results into packed BCD for display and BCD-consuming logic.
- Start/busy/done handshake. Result is held registered until the next conversion completes.

Parameters:
- WIDTH, 8, binary input width in bits; legal values are 2 to 32.
- DIGITS, 3, number of BCD digits in the output. It must satisfy DIGITS >= ceil(WIDTH*log10(2)). An elaboration-time check fails the build otherwise.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin  input  WIDTH  unsigned binary operand; captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress (CONV state).
- done  output  1  single-cycle pulse when bcd holds a new result.
- bcd  output  4*DIGITS  packed BCD result; digit k is bcd[4k+3:4k], with digit 0 = units.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, bcd=0, and all internal shift/scratch registers cleared.
- Reset during a conversion aborts it. No done pulse is issued, and bcd reads 0.
- Internal state: a shift register sh[WIDTH-1:0], a scratch BCD register acc[4*DIGITS-1:0], and a bit counter cnt of width $clog2(WIDTH+1).
- FSM states are IDLE, CONV and DONE.
- IDLE: busy=0, done=0. If start=1 at an edge, then sh<=bin, acc<=0, cnt<=WIDTH, and the FSM goes to CONV. Otherwise it stays in IDLE.
- CONV: busy=1. On each edge, every acc digit >=5 first gets +3, all digits in parallel and combinationally. Then {acc,sh} shifts left by 1, so the MSB of sh enters acc bit 0, and cnt<=cnt-1.
- When cnt==1 at an edge, that edge performs the final shift and the FSM goes to DONE.
- DONE: done=1 and busy=0 for exactly one cycle. bcd is loaded from the final acc on the edge entering DONE. The next edge returns to IDLE.
- Latency: if start is accepted at edge E0, then busy is high for the WIDTH cycles following E0. done and the new bcd are visible after edge E0+WIDTH. For default WIDTH=8, done is high in the 9th cycle after the accepting edge.
- Throughput: one conversion per WIDTH+2 cycles. This is achieved when start is held high, because start is re-sampled in IDLE.
- start while in CONV or DONE: ignored, with no queuing.
- Changes on bin after acceptance: no effect on the running conversion.
- bcd holds its previous value through CONV and DONE-entry until it is overwritten. It is never partially updated.
- Overflow is impossible given the DIGITS constraint. Every output digit is always in the range 0 to 9.
- The add-3 correction applies to all DIGITS digits, including the top digit, even though that digit never reaches 5 before the final shift under legal parameters.

Test Plan:
- Reset, then start with bin=8'd0: busy high for 8 cycles, done pulse in cycle 9, bcd=12'h000.
- bin=8'd255: bcd=12'h255. bin=8'd19: bcd=12'h019. bin=8'd100: bcd=12'h100.
- Exhaustive sweep bin=0..255, comparing against a reference model (hundreds, tens, units computed by division): every result matches, every done is exactly one cycle, and there is no digit >9.
- Start held high with bin switching from 8'd37 to 8'd200 mid-conversion: first result is 12'h037, then the second conversion starts at the next IDLE edge and gives 12'h200. Extra start pulses during busy produce no extra done.
- Assert rst_n low at cycle 4 of a conversion of 8'd99: busy, done and bcd go to 0 immediately (asynchronously) and no done follows. After release, converting 8'd99 gives 12'h099.
- Parameter variant WIDTH=12, DIGITS=4: bin=12'd4095 gives bcd=16'h4095, with done 13 cycles after the accepting edge.
